// File: rtl/pulpemu_stdout_flush_ctrl_if.sv
// Core-write and host-flush signals of the stdout flush scheduler.
// The slave modport is the scheduler side; the master modport is the side that
// drives core writes and host acks.
interface pulpemu_stdout_flush_ctrl_if #(
    parameter int NB_CORES = 4,
    parameter int CW       = 15
);
    localparam int CORE_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;

    logic                         wr_valid;
    logic [CORE_W-1:0]            wr_core;
    logic                         wr_ready;
    logic [NB_CORES-1:0][CW-1:0]  level;
    logic                         flush_req;
    logic [NB_CORES-1:0]          flush_mask;
    logic                         flush_ack;
    logic                         stdout_flushed;
    logic                         stdout_wait;
    logic                         timeout_err;

    modport master (
        output wr_valid, wr_core, flush_ack,
        input  wr_ready, level, flush_req, flush_mask,
               stdout_flushed, stdout_wait, timeout_err
    );

    modport slave (
        input  wr_valid, wr_core, flush_ack,
        output wr_ready, level, flush_req, flush_mask,
               stdout_flushed, stdout_wait, timeout_err
    );
endinterface

// File: rtl/pulpemu_stdout_flush_ctrl.sv
// Stdout flush scheduler: per-core fill tracking, flush decision (threshold,
// idle timeout, end of run), host request/ack handshake and write stalling.

// Per-core byte counter.
module pulpemu_stdout_flush_lvl #(
    parameter int CW = 15
) (
    input  logic          ref_clk_i,
    input  logic          rst_ni,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] level,
    output logic [CW-1:0] level_next
);
    // Next level; a clear beats a same-cycle increment.
    always_comb begin
        level_next = level;
        if (clr)
            level_next = '0;
        else if (inc)
            level_next = level + CW'(1);
    end

    // Level register.
    always_ff @(posedge ref_clk_i or negedge rst_ni) begin
        if (!rst_ni)
            level <= '0;
        else
            level <= level_next;
    end
endmodule

module pulpemu_stdout_flush_ctrl #(
    parameter int STDOUT_BUFFER_DIM = 65536,
    parameter int NB_CORES          = 4,
    parameter int IDLE_TIMEOUT      = 4096,
    parameter int ACK_TIMEOUT       = 1048576
) (
    input  logic                       ref_clk_i,
    input  logic                       rst_ni,
    input  logic                       fetch_en_i,
    pulpemu_stdout_flush_ctrl_if.slave bus
);
    localparam int CAP    = STDOUT_BUFFER_DIM / NB_CORES;
    localparam int CW     = $clog2(CAP) + 1;
    localparam int THR    = CAP / 16 * 15;
    localparam int CORE_W = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int IW     = $clog2(IDLE_TIMEOUT);
    // One spare count so the counter can park past the timeout value and
    // the error is raised only once per request.
    localparam int AW     = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ARMED, REQ, DONE} state_e;

    state_e                      state_q, state_d;
    logic                        fetch_q, rise, fall, acc, clr_lvl, any_thr;
    logic [NB_CORES-1:0]         inc, thr_hit, nz_next;
    logic [NB_CORES-1:0][CW-1:0] lvl_q, lvl_d;
    logic [IW-1:0]               idle_q;
    logic [AW-1:0]               ack_q;
    logic [NB_CORES-1:0]         mask_q;
    logic                        err_q, wait_q;

    assign rise    = fetch_en_i & ~fetch_q;
    assign fall    = ~fetch_en_i & fetch_q;
    assign acc     = bus.wr_valid & bus.wr_ready;
    assign clr_lvl = rise | (state_q == DONE);
    assign any_thr = |thr_hit;

    for (genvar g = 0; g < NB_CORES; g++) begin : g_lane
        assign inc[g] = acc && (bus.wr_core == CORE_W'(g));
        pulpemu_stdout_flush_lvl #(.CW(CW)) u_lvl (
            .ref_clk_i  (ref_clk_i),
            .rst_ni     (rst_ni),
            .clr        (clr_lvl),
            .inc        (inc[g]),
            .level      (lvl_q[g]),
            .level_next (lvl_d[g])
        );
        assign thr_hit[g] = lvl_q[g] >= CW'(THR);
        assign nz_next[g] = |lvl_d[g];
    end

    // Writes are only taken outside a flush and never past a core's capacity.
    assign bus.wr_ready       = ((state_q == IDLE) || (state_q == ARMED)) &&
                                (lvl_q[bus.wr_core] < CW'(CAP));
    assign bus.level          = lvl_q;
    assign bus.flush_req      = (state_q == REQ);
    assign bus.stdout_flushed = (state_q == DONE);
    assign bus.flush_mask     = mask_q;
    assign bus.stdout_wait    = wait_q;
    assign bus.timeout_err    = err_q;

    // Flush decision FSM: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (acc) state_d = ARMED;
            ARMED: if (any_thr || (idle_q == IW'(IDLE_TIMEOUT - 1)) || fall)
                       state_d = REQ;
            REQ:   if (bus.flush_ack) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register, timers, request mask, error and back-pressure flags.
    always_ff @(posedge ref_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            fetch_q <= 1'b0;
            idle_q  <= '0;
            ack_q   <= '0;
            mask_q  <= '0;
            err_q   <= 1'b0;
            wait_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fetch_q <= fetch_en_i;
            idle_q  <= (state_q == ARMED && !acc) ? idle_q + IW'(1) : '0;
            wait_q  <= any_thr || (state_q == REQ) || (state_q == DONE);
            if (state_q == ARMED && state_d == REQ) begin
                mask_q <= nz_next;
                ack_q  <= '0;
            end else if (state_q == REQ && ack_q != AW'(ACK_TIMEOUT)) begin
                ack_q <= ack_q + AW'(1);
            end
            if (state_q == DONE)
                mask_q <= '0;
            // A same-cycle ack takes precedence over the timeout.
            if (state_q == REQ && !bus.flush_ack && ack_q == AW'(ACK_TIMEOUT - 1))
                err_q <= 1'b1;
            if (rise)
                err_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pulpemu_stdout_flush_ctrl.sv
// Bench for the stdout flush scheduler: directed scenarios with hand-derived
// timing plus randomized traffic against a behavioural model.
module tb_pulpemu_stdout_flush_ctrl;
    localparam int DIM = 256;
    localparam int NC  = 4;
    localparam int IT  = 16;
    localparam int AT  = 32;
    localparam int CAP = DIM / NC;
    localparam int THR = CAP / 16 * 15;
    localparam int CW  = $clog2(CAP) + 1;

    logic ref_clk = 1'b0;
    logic rst_n   = 1'b0;
    logic fetch_en = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pulpemu_stdout_flush_ctrl_if #(.NB_CORES(NC), .CW(CW)) bus ();

    pulpemu_stdout_flush_ctrl #(
        .STDOUT_BUFFER_DIM (DIM),
        .NB_CORES          (NC),
        .IDLE_TIMEOUT      (IT),
        .ACK_TIMEOUT       (AT)
    ) dut (
        .ref_clk_i  (ref_clk),
        .rst_ni     (rst_n),
        .fetch_en_i (fetch_en),
        .bus        (bus)
    );

    always #5 ref_clk = ~ref_clk;

    // ---------------- behavioural model ----------------
    // mode: 0 idle, 1 collecting, 2 waiting for host, 3 flushed
    int             m_lvl [NC];
    int             m_mode, m_idle, m_req_cyc;
    logic [NC-1:0]  m_mask;
    bit             m_err, m_wait, m_fq;

    task automatic model_reset();
        foreach (m_lvl[i]) m_lvl[i] = 0;
        m_mode = 0; m_idle = 0; m_req_cyc = 0;
        m_mask = '0; m_err = 0; m_wait = 0; m_fq = 0;
    endtask

    function automatic bit m_ready();
        return (m_mode < 2) && (m_lvl[bus.wr_core] < CAP);
    endfunction

    function automatic logic [NC*CW-1:0] m_level();
        logic [NC*CW-1:0] r;
        for (int i = 0; i < NC; i++) r[i*CW +: CW] = CW'(m_lvl[i]);
        return r;
    endfunction

    task automatic model_step();
        bit acc, rise, fall, hit, clr, nerr;
        int nl [NC];
        int nmode;
        logic [NC-1:0] nmask;
        acc  = bus.wr_valid && m_ready();
        rise = fetch_en && !m_fq;
        fall = !fetch_en && m_fq;
        hit  = 0;
        foreach (m_lvl[i]) if (m_lvl[i] >= THR) hit = 1;
        clr  = rise || (m_mode == 3);
        for (int i = 0; i < NC; i++)
            nl[i] = clr ? 0 : m_lvl[i] + ((acc && bus.wr_core == i) ? 1 : 0);
        nmode = m_mode; nmask = m_mask; nerr = m_err;
        case (m_mode)
            0: if (acc) nmode = 1;
            1: if (hit || m_idle == IT - 1 || fall) begin
                   nmode = 2;
                   for (int i = 0; i < NC; i++) nmask[i] = (nl[i] != 0);
               end
            2: if (bus.flush_ack) nmode = 3;
               else if (m_req_cyc == AT) nerr = 1;
            default: begin nmode = 0; nmask = '0; end
        endcase
        if (rise) nerr = 0;
        m_wait    = hit || (m_mode >= 2);
        m_idle    = (m_mode == 1 && !acc) ? m_idle + 1 : 0;
        m_req_cyc = (nmode == 2) ? ((m_mode == 2) ? m_req_cyc + 1 : 1) : 0;
        foreach (m_lvl[i]) m_lvl[i] = nl[i];
        m_mode = nmode; m_mask = nmask; m_err = nerr; m_fq = fetch_en;
    endtask

    // Inputs change at posedge+1; outputs are looked at on the negedge.
    task automatic settle();
        @(negedge ref_clk);
    endtask

    task automatic adv();
        model_step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic drive(input bit v, input int core, input bit ack);
        bus.wr_valid  = v;
        bus.wr_core   = 2'(core);
        bus.flush_ack = ack;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [NC*CW+NC+5-1:0] got;
        drive(0, 0, 0);
        rst_n = 1'b0; fetch_en = 1'b1;
        model_reset();
        settle();
        got = {bus.level, bus.flush_mask, bus.wr_ready, bus.flush_req,
               bus.stdout_flushed, bus.stdout_wait, bus.timeout_err};
        n_tests++;
        if (got !== {{(NC*CW+NC){1'b0}}, 5'b10000}) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", got, {{(NC*CW+NC){1'b0}}, 5'b10000});
        end
        @(posedge ref_clk); #1;
        rst_n = 1'b1;
        adv();   // absorb the run-start edge seen right after reset
    endtask

    task automatic test_threshold();
        logic [3:0] got, exp;
        logic [NC-1:0][CW-1:0] lv;
        for (int c = 0; c < 68; c++) begin
            drive(c <= 64, 2, c == 65);
            settle();
            got = {bus.wr_ready, bus.flush_req, bus.stdout_wait, bus.stdout_flushed};
            exp = {(c <= 60 || c >= 67), (c >= 61 && c <= 65), (c >= 61 && c <= 67), (c == 66)};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL thr_flags c=%0d: got %b want %b", c, got, exp);
            end
            if (c == 60 || c == 61 || c == 67) begin
                lv = '0;
                lv[2] = (c == 60) ? CW'(60) : (c == 61) ? CW'(61) : CW'(0);
                n_tests++;
                if (bus.level !== lv || bus.flush_mask !== ((c == 61) ? 4'b0100 : 4'b0000)) begin
                    n_fail++; $display("FAIL thr_level c=%0d: got %h/%b want %h/%b", c,
                                       bus.level, bus.flush_mask, lv, (c == 61) ? 4'b0100 : 4'b0000);
                end
            end
            adv();
        end
    endtask

    task automatic test_idle_timeout();
        logic [3:0] got, exp;
        for (int c = 0; c < 26; c++) begin
            drive(c <= 2, 1, c == 21);
            settle();
            got = {bus.wr_ready, bus.flush_req, bus.stdout_wait, bus.stdout_flushed};
            exp = {(c <= 18 || c >= 23), (c >= 19 && c <= 21), (c >= 20 && c <= 23), (c == 22)};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL idle_flags c=%0d: got %b want %b", c, got, exp);
            end
            if (c == 19 || c == 23) begin
                n_tests++;
                if (bus.flush_mask !== ((c == 19) ? 4'b0010 : 4'b0000) ||
                    bus.level !== ((c == 19) ? m_level() : '0)) begin
                    n_fail++; $display("FAIL idle_mask c=%0d: got %b/%h", c, bus.flush_mask, bus.level);
                end
            end
            adv();
        end
    endtask

    task automatic test_end_of_run();
        logic [3:0] got, exp;
        logic [NC-1:0][CW-1:0] lv;
        for (int c = 0; c < 20; c++) begin
            drive(c <= 6, (c <= 4) ? 0 : 3, c == 9);
            fetch_en = !((c >= 7 && c <= 11) || (c >= 14 && c <= 17));
            settle();
            got = {bus.wr_ready, bus.flush_req, bus.stdout_wait, bus.stdout_flushed};
            exp = {!(c >= 8 && c <= 10), (c >= 8 && c <= 9), (c >= 9 && c <= 11), (c == 10)};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL eor_flags c=%0d: got %b want %b", c, got, exp);
            end
            if (c == 8) begin
                lv = '0; lv[0] = CW'(5); lv[3] = CW'(2);
                n_tests++;
                if (bus.flush_mask !== 4'b1001 || bus.level !== lv) begin
                    n_fail++; $display("FAIL eor_mask: got %b/%h want 1001/%h", bus.flush_mask, bus.level, lv);
                end
            end
            adv();
        end
    endtask

    task automatic test_ack_timeout();
        logic [2:0] got, exp;
        for (int c = 0; c < 50; c++) begin
            drive(c == 0, 1, c == 42);
            fetch_en = !(c >= 1 && c <= 45);
            settle();
            got = {bus.flush_req, bus.stdout_flushed, bus.timeout_err};
            exp = {(c >= 2 && c <= 42), (c == 43), (c >= 34 && c <= 46)};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL timeout_flags c=%0d: got %b want %b", c, got, exp);
            end
            adv();
        end
    endtask

    task automatic test_saturate();
        logic [NC-1:0][CW-1:0] lv;
        bool_check: for (int c = 0; c < 75; c++) begin
            drive((c <= 70), (c == 60) ? 1 : 0, c == 71);
            settle();
            n_tests++;
            if (bus.level !== m_level() || bus.wr_ready !== m_ready()) begin
                n_fail++; $display("FAIL sat_model c=%0d: got %h/%b want %h/%b", c,
                                   bus.level, bus.wr_ready, m_level(), m_ready());
            end
            for (int i = 0; i < NC; i++) begin
                n_tests++;
                if (bus.level[i] > CW'(CAP)) begin
                    n_fail++; $display("FAIL sat_cap c=%0d core=%0d: got %0d limit %0d", c, i, bus.level[i], CAP);
                end
            end
            if (c == 61) begin
                lv = '0; lv[0] = CW'(60); lv[1] = CW'(1);
                n_tests++;
                if (bus.level !== lv || bus.flush_mask !== 4'b0011) begin
                    n_fail++; $display("FAIL sat_mask: got %h/%b want %h/0011", bus.level, bus.flush_mask, lv);
                end
            end
            if (c >= 61 && c <= 71) begin
                n_tests++;
                if (bus.wr_ready !== 1'b0) begin
                    n_fail++; $display("FAIL sat_stall c=%0d: got %b want 0", c, bus.wr_ready);
                end
            end
            adv();
        end
    endtask

    task automatic test_reset_mid_flush();
        logic [NC*CW+NC+5-1:0] got;
        for (int c = 0; c < 4; c++) begin
            drive(c == 0, 2, 0);
            fetch_en = (c == 0);
            settle();
            adv();
        end
        settle();
        n_tests++;
        if (bus.flush_req !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup: got %b want 1", bus.flush_req);
        end
        #2 rst_n = 1'b0;
        #1;
        got = {bus.level, bus.flush_mask, bus.wr_ready, bus.flush_req,
               bus.stdout_flushed, bus.stdout_wait, bus.timeout_err};
        n_tests++;
        if (got !== {{(NC*CW+NC){1'b0}}, 5'b10000}) begin
            n_fail++; $display("FAIL rstmid_async: got %h want %h", got, {{(NC*CW+NC){1'b0}}, 5'b10000});
        end
        fetch_en = 1'b1;
        @(posedge ref_clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            drive(0, 0, c[0]);
            settle();
            n_tests++;
            if ({bus.wr_ready, bus.flush_req, bus.stdout_flushed} !== 3'b100 || bus.level !== '0) begin
                n_fail++; $display("FAIL rstmid_ack c=%0d: got %b/%h want 100/0", c,
                                   {bus.wr_ready, bus.flush_req, bus.stdout_flushed}, bus.level);
            end
            adv();
        end
    endtask

    task automatic test_random();
        logic [NC*CW+NC+5-1:0] got, exp;
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, NC - 1), $urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 3) fetch_en = !fetch_en;
            settle();
            got = {bus.level, bus.flush_mask, bus.wr_ready, bus.flush_req,
                   bus.stdout_flushed, bus.stdout_wait, bus.timeout_err};
            exp = {m_level(), m_mask, m_ready(), m_mode == 2, m_mode == 3, m_wait, m_err};
            n_tests++;
            if (got !== exp) begin
                n_fail++; $display("FAIL random c=%0d: got %h want %h", c, got, exp);
            end
            adv();
        end
    endtask

    initial begin
        test_reset();
        test_threshold();
        test_idle_timeout();
        test_end_of_run();
        test_ack_timeout();
        test_saturate();
        test_reset_mid_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
